// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter: one registered one-hot grant, held until release or request drop.
// Optional grant-length limit enabled by defining ARB_TIMEOUT_EN.

// Protocol checker: one-hot grant, consistent busy/index, index kept in range.
module rr_bus_arbiter_chk #(
    parameter int WIDTH     = 5,
    parameter int TIMEOUT   = 16,
    parameter int IDX_WIDTH = 3
) (
    input logic                 clk,
    input logic                 rst,
    input logic [WIDTH-1:0]     grant,
    input logic [IDX_WIDTH-1:0] grant_idx,
    input logic                 busy,
    input logic                 timeout
);
    a_params_legal: assert property (@(posedge clk) (WIDTH > 1) && (TIMEOUT >= 1));
    a_onehot_when_busy: assert property (@(posedge clk) disable iff (rst) busy |-> $onehot(grant));
    a_busy_matches_grant: assert property (@(posedge clk) disable iff (rst) busy == (|grant));
    a_idx_in_range: assert property (@(posedge clk) disable iff (rst) int'(grant_idx) < WIDTH);
    a_idx_matches_grant: assert property (@(posedge clk) disable iff (rst) busy |-> grant[grant_idx]);
    a_idle_idx_zero: assert property (@(posedge clk) disable iff (rst) !busy |-> (grant_idx == '0));
    a_timeout_single: assert property (@(posedge clk) disable iff (rst) timeout |=> !timeout);
endmodule

module rr_bus_arbiter #(
    parameter  int WIDTH     = 5,
    parameter  int TIMEOUT   = 16,
    localparam int IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WIDTH-1:0]     iv_req,
    input  logic                 i_release,
    output logic [WIDTH-1:0]     ov_grant,
    output logic [IDX_WIDTH-1:0] ov_grant_idx,
    output logic                 o_busy,
    output logic                 o_timeout
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 state_r;
    logic [IDX_WIDTH-1:0]   last_r;
    logic [IDX_WIDTH-1:0]   win_idx_s;
    logic [WIDTH-1:0]       win_vec_s;
    logic                   owner_req_s;

`ifdef ARB_TIMEOUT_EN
    localparam int TEN_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TEN_W-1:0]       tenure_r;
`endif

    // Rotate so the previous owner sits at bit 0, take the highest set bit, rotate back.
    function automatic logic [IDX_WIDTH-1:0] rr_pick(
        input logic [WIDTH-1:0]     req,
        input logic [IDX_WIDTH-1:0] last
    );
        logic [WIDTH-1:0] rot;
        int               src;
        int               win;
        rot = '0;
        win = 0;
        for (int k = 0; k < WIDTH; k++) begin
            src = k + int'(last);
            if (src >= WIDTH) begin
                src = src - WIDTH;
            end else begin
                src = src;
            end
            rot[k] = req[src];
        end
        for (int k = 0; k < WIDTH; k++) begin
            if (rot[k]) begin
                win = k;
            end else begin
                win = win;
            end
        end
        src = win + int'(last);
        if (src >= WIDTH) begin
            src = src - WIDTH;
        end else begin
            src = src;
        end
        return IDX_WIDTH'(src);
    endfunction

    // Next winner and whether the current owner still requests.
    always_comb begin
        win_idx_s   = rr_pick(iv_req, last_r);
        win_vec_s   = {{(WIDTH-1){1'b0}}, 1'b1} << win_idx_s;
        owner_req_s = |(iv_req & ov_grant);
    end

    // Arbitration FSM with registered grant outputs and last-owner pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            ov_grant     <= '0;
            ov_grant_idx <= '0;
            o_busy       <= 1'b0;
            o_timeout    <= 1'b0;
            last_r       <= '0;
`ifdef ARB_TIMEOUT_EN
            tenure_r     <= '0;
`endif
        end else begin
            o_timeout <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|iv_req) begin
                        state_r      <= ST_GRANT;
                        ov_grant     <= win_vec_s;
                        ov_grant_idx <= win_idx_s;
                        o_busy       <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        tenure_r     <= '0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (i_release || !owner_req_s) begin
                        state_r      <= ST_IDLE;
                        ov_grant     <= '0;
                        ov_grant_idx <= '0;
                        o_busy       <= 1'b0;
                        last_r       <= ov_grant_idx;
`ifdef ARB_TIMEOUT_EN
                    end else if (tenure_r == TEN_W'(TIMEOUT - 1)) begin
                        // Revoked owner becomes lowest priority, same as a release.
                        state_r      <= ST_IDLE;
                        ov_grant     <= '0;
                        ov_grant_idx <= '0;
                        o_busy       <= 1'b0;
                        last_r       <= ov_grant_idx;
                        o_timeout    <= 1'b1;
                    end else begin
                        tenure_r <= tenure_r + TEN_W'(1);
`else
                    end else begin
                        state_r <= ST_GRANT;
`endif
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    ov_grant     <= '0;
                    ov_grant_idx <= '0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

    rr_bus_arbiter_chk #(
        .WIDTH     (WIDTH),
        .TIMEOUT   (TIMEOUT),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_chk (
        .clk       (i_clk),
        .rst       (i_rst),
        .grant     (ov_grant),
        .grant_idx (ov_grant_idx),
        .busy      (o_busy),
        .timeout   (o_timeout)
    );
endmodule
